coin_intake: RTL
================

// Module: coin_intake
// PURPOSE
//   Front end for the four coin beam-break sensors (penny, nickel, dime, quarter).
//   Synchronises and debounces each raw sensor and turns each debounced beam-break
//   into a coin event. Keeps a running cents total and per-coin counts, and queues
//   events for the CPU through a valid/ack handshake.
//   Sits between the JB1..JB4 pins and the MMIO read mux, which it feeds. It is driven
//   by MMIO write strobes for ack and clear.
// PARAMETERS
//   DEBOUNCE_CYCLES  30000  consecutive stable cycles needed to accept a level (1 ms @ 30 MHz); must be >= 2
//   BROKEN_LEVEL     0      raw pin level that means "beam broken"
//   TOTAL_W          16     width of total_cents
// PORTS
//   clock        in   1        system clock (30 MHz PLL output)
//   reset        in   1        asynchronous, active-low reset (0 = reset)
//   beam_raw     in   4        raw sensor pins; [0]=penny [1]=nickel [2]=dime [3]=quarter
//   coin_ack     in   1        one-cycle pulse: CPU consumed the presented event
//   clear        in   1        one-cycle pulse: zero totals, counts, queue and overflow
//   beam_state   out  4        debounced level per channel; 1 = broken
//   coin_valid   out  1        an event is pending
//   coin_type    out  2        type of the presented event; 0=penny 1=nickel 2=dime 3=quarter
//   total_cents  out  TOTAL_W  saturating sum of accepted coin values
//   coin_counts  out  32       {quarter, dime, nickel, penny}; each field 8 bits, saturating
//   overflow     out  1        sticky: an event arrived while its channel was already pending
// BEHAVIOUR
//   Reset (reset=0, async):
//   - All outputs 0. Sync flops, debounce counters and pending bits cleared.
//   - Debounced state set to "not broken".
//   Synchroniser: 2 flops per channel; s2 is the synchronised level, compared as (s2 == BROKEN_LEVEL).
//   Debounce, per channel (cnt: counter; stable: beam_state bit):
//   - s2 == stable: cnt <= 0.
//   - Mismatch and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - Mismatch and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
//   - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no change.
//   Event:
//   - The edge where stable goes 0->1 is the event edge. Release (1->0) produces no event.
//   - Latency: a clean raw step first sampled at edge k is seen after edge k+1+DEBOUNCE_CYCLES,
//     in beam_state, pending, total_cents and coin_counts.
//   Accounting, at the event edge:
//   - total_cents += value (1/5/10/25), saturating at 2^TOTAL_W-1.
//   - Matching 8-bit count += 1, saturating at 255.
//   - Simultaneous events on several channels: all are added the same cycle.
//   Queue: 4 pending bits, one per channel.
//   - coin_valid = |pending.
//   - coin_type = highest set bit (quarter > dime > nickel > penny).
//   - Both are decoded from registered pending bits; no combinational path from inputs.
//   Handshake:
//   - coin_ack with coin_valid=1 clears pending[coin_type] at that edge.
//   - Next lower-priority pending event is presented the following cycle.
//   - coin_ack with coin_valid=0 is ignored.
//   - Ack and a new event on the same channel in the same cycle: pending stays 1, no overflow.
//   - Event on a channel whose pending bit is 1 and not being acked: overflow <= 1. Event is
//     still counted in total/counts; queue holds one entry per channel.
//   Clear:
//   - Zeros total_cents, coin_counts, pending and overflow at the edge.
//   - Clear wins over an event or ack in the same cycle; that event is discarded entirely.
//   - Debounce state and beam_state are unaffected.
//   Mid-operation reset: any partial debounce is abandoned. A beam still broken after reset
//   release produces one event DEBOUNCE_CYCLES+2 edges later.
// TESTING (DEBOUNCE_CYCLES=4, BROKEN_LEVEL=0)
//   1. Drop beam_raw[2] to 0 and hold:
//      - edge k+5: coin_valid=1, coin_type=2, total_cents=10, coin_counts=32'h00_01_00_00.
//      - Pulse coin_ack: coin_valid=0 next cycle.
//   2. Glitch beam_raw[0] low for 3 cycles -> no event; beam_state, total_cents and counts unchanged.
//   3. Break quarter and penny in the same cycle:
//      - total_cents=26; coin_type=3 first.
//      - After ack, coin_type=0 the next cycle; after second ack, coin_valid=0.
//   4. Two nickel events without ack -> overflow=1, total_cents=10, nickel count=2, one pending entry.
//   5. Drive 2622 quarter events with TOTAL_W=16:
//      - total_cents saturates at 65535; quarter count saturates at 255.
//      - clear -> all zero; an event in the clear cycle is lost.
//   6. Assert reset with dime at cnt=2 -> outputs 0. Release with dime still broken -> one dime event 6 edges later.

Source files
------------

// File: rtl/coin_intake_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_intake_if
// Description : CPU-facing bundle of the coin intake block. Carries the ack and
//               clear write strobes and the read-mux status fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_intake_if #(
  parameter int TOTAL_W = 16
);
  logic               coin_ack;
  logic               clear;
  logic [3:0]         beam_state;
  logic               coin_valid;
  logic [1:0]         coin_type;
  logic [TOTAL_W-1:0] total_cents;
  logic [31:0]        coin_counts;
  logic               overflow;

  // CPU / MMIO side: issues strobes, reads status
  modport master (
    output coin_ack, clear,
    input  beam_state, coin_valid, coin_type, total_cents, coin_counts, overflow
  );

  // Coin intake side: accepts strobes, drives status
  modport slave (
    input  coin_ack, clear,
    output beam_state, coin_valid, coin_type, total_cents, coin_counts, overflow
  );
endinterface
`default_nettype wire

// File: rtl/coin_intake.sv
`default_nettype none
// ============================================================================
// Module      : coin_intake
// Description : Synchronises and debounces four coin beam-break sensors
//               (penny, nickel, dime, quarter), turns each debounced break into
//               a coin event, keeps saturating totals/counts and queues one
//               pending event per channel behind a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_intake #(
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter bit BROKEN_LEVEL    = 1'b0,
  parameter int TOTAL_W         = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    beam_raw,
  coin_intake_if.slave  bus
);

  localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Idle ("not broken") pin level; sync flops reset here so that reset itself
  // never looks like a beam break to the debouncer.
  localparam logic [3:0]      c_IDLE     = {4{~BROKEN_LEVEL}};

  // Coin value in cents for channel index 0..3
  function automatic logic [5:0] coin_value(input int ch);
    case (ch)
      0:       coin_value = 6'd1;
      1:       coin_value = 6'd5;
      2:       coin_value = 6'd10;
      default: coin_value = 6'd25;
    endcase
  endfunction

  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         w_level;
  logic [3:0]         w_stable;
  logic [3:0]         w_event;
  logic [3:0]         r_pending;
  logic               r_overflow;
  logic [TOTAL_W-1:0] r_total;
  logic [1:0]         w_type;
  logic [3:0]         w_ack_mask;
  logic [3:0]         w_pending_next;
  logic               w_ovf;
  logic [5:0]         w_add;
  logic [TOTAL_W+5:0] w_sum;
  logic [TOTAL_W-1:0] w_total_next;

  // Two-flop synchroniser on the raw sensor pins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= c_IDLE;
      r_sync2 <= c_IDLE;
    end else begin
      r_sync1 <= beam_raw;
      r_sync2 <= r_sync1;
    end
  end

  // 1 = synchronised level says the beam is broken
  assign w_level = BROKEN_LEVEL ? r_sync2 : ~r_sync2;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic [7:0]       r_count;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_level[i] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_stable <= w_level[i];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    // Event only on the not-broken -> broken transition of the debounced level
    assign w_event[i]  = w_level[i] & ~r_stable & (r_cnt == c_CNT_LAST);
    assign w_stable[i] = r_stable;

    // Per-coin count, saturating at 255; clear discards a same-cycle event
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_count <= 8'd0;
      end else if (bus.clear) begin
        r_count <= 8'd0;
      end else if (w_event[i] && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end

    assign bus.coin_counts[8*i +: 8] = r_count;
  end

  // Present the highest-value pending coin
  always_comb begin
    w_type = 2'd0;
    if (r_pending[3])      w_type = 2'd3;
    else if (r_pending[2]) w_type = 2'd2;
    else if (r_pending[1]) w_type = 2'd1;
  end

  // Queue update, overflow detection and saturating cents total
  always_comb begin
    w_ack_mask = 4'b0000;
    if (bus.coin_ack && (r_pending != 4'b0000)) w_ack_mask = 4'b0001 << w_type;
    w_pending_next = (r_pending & ~w_ack_mask) | w_event;
    w_ovf          = |(w_event & r_pending & ~w_ack_mask);
    w_add          = 6'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_event[i]) w_add = w_add + coin_value(i);
    end
    w_sum        = {6'd0, r_total} + {{TOTAL_W{1'b0}}, w_add};
    w_total_next = (|w_sum[TOTAL_W+5:TOTAL_W]) ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
  end

  // Accounting state; clear has priority over events and acks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending  <= 4'b0000;
      r_overflow <= 1'b0;
      r_total    <= '0;
    end else if (bus.clear) begin
      r_pending  <= 4'b0000;
      r_overflow <= 1'b0;
      r_total    <= '0;
    end else begin
      r_pending <= w_pending_next;
      r_total   <= w_total_next;
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  assign bus.beam_state  = w_stable;
  assign bus.coin_valid  = |r_pending;
  assign bus.coin_type   = w_type;
  assign bus.total_cents = r_total;
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire
